// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
interface if_stage_if;
  logic [31:0] IM_Addr;
  logic        IM_Req;
  logic        IM_Ready;
  logic [31:0] IM_Data;

  modport master (output IM_Addr, IM_Req, input IM_Ready, IM_Data);
  modport slave  (input IM_Addr, IM_Req, output IM_Ready, IM_Data);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection, and a one-word hold buffer
// that keeps a fetched instruction stable while the decode stage is stalled.
//
// state | meaning
// FETCH | request IM at PC; word is presented combinationally when IM_Ready
// HOLD  | decode stalled; present buffered word, no memory request
module if_stage (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         IF_Stall,
  input  logic [2:0]   PCsrc,
  input  logic [31:0]  BranchTarget,
  input  logic [31:0]  JumpTarget,
  input  logic [31:0]  JrTarget,
  if_stage_if.master   im,
  output logic [31:0]  IF_instruct,
  output logic [31:0]  IF_PCplus4,
  output logic         IF_Valid,
  output logic         IF_Flush
);

  localparam logic [31:0] PC_RESET = 32'h8000_0000;
  localparam logic [31:0] PC_ILLOP = 32'h8000_0004;
  localparam logic [31:0] PC_XADR  = 32'h8000_0008;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_seq;
  logic [31:0] redirect_pc;
  logic        redirect;
  logic        valid_raw;
  logic        consumed;

  // Bit 31 is the supervisor bit and never receives a carry from the increment.
  always_comb pc_seq = {pc_q[31], pc_q[30:0] + 31'd4};

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pc_seq;
    case (PCsrc)
      3'd1: begin
        redirect    = 1'b1;
        redirect_pc = {pc_q[31], 31'b0} | (BranchTarget & 32'h7FFF_FFFC);
      end
      3'd2: begin
        redirect    = 1'b1;
        redirect_pc = {pc_q[31], 31'b0} | (JumpTarget & 32'h7FFF_FFFC);
      end
      3'd3: begin
        // User mode cannot raise the supervisor bit through a register jump.
        redirect    = 1'b1;
        redirect_pc = JrTarget & {pc_q[31], 31'h7FFF_FFFC};
      end
      3'd4: begin
        redirect    = 1'b1;
        redirect_pc = PC_ILLOP;
      end
      3'd5: begin
        redirect    = 1'b1;
        redirect_pc = PC_XADR;
      end
      default: begin
        redirect    = 1'b0;
        redirect_pc = pc_seq;
      end
    endcase
  end

  always_comb valid_raw = (state_q == HOLD) ? 1'b1 : im.IM_Ready;
  always_comb consumed  = valid_raw && !IF_Stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (redirect) begin
      state_d = FETCH;
      pc_d    = redirect_pc;
      buf_d   = 32'h0;
    end else begin
      case (state_q)
        FETCH: begin
          if (im.IM_Ready && IF_Stall) begin
            state_d = HOLD;
            buf_d   = im.IM_Data;
          end else if (consumed) begin
            pc_d = pc_seq;
          end
        end
        HOLD: begin
          if (!IF_Stall) begin
            state_d = FETCH;
            pc_d    = pc_seq;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs are forced to their idle values for as long as Reset is held.
  always_comb begin
    im.IM_Addr  = pc_q & 32'hFFFF_FFFC;
    im.IM_Req   = 1'b0;
    IF_Valid    = 1'b0;
    IF_Flush    = 1'b0;
    IF_instruct = 32'h0;
    IF_PCplus4  = PC_RESET + 32'd4;
    if (!Reset) begin
      im.IM_Req   = (state_q == FETCH);
      IF_Valid    = valid_raw;
      IF_Flush    = redirect;
      IF_instruct = (state_q == HOLD) ? buf_q : im.IM_Data;
      IF_PCplus4  = pc_seq;
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port IF_Stall, input, 1 bit: downstream load-use hold; the presented instruction is not consumed.
REQ-004 SHALL have port PCsrc, input, 3 bits: next-PC select; 0 sequential, 1 branch, 2 jump, 3 jump-register, 4 ILLOP vector, 5 XADR vector, 6/7 treated as 0.
REQ-005 SHALL have ports BranchTarget, JumpTarget, JrTarget, inputs, 32 bits each: redirect targets.
REQ-006 SHALL have port IM_Addr, output, 32 bits: instruction memory word address.
REQ-007 SHALL have port IM_Req, output, 1 bit: fetch request.
REQ-008 SHALL have port IM_Ready, input, 1 bit: IM_Data is valid for the current IM_Addr.
REQ-009 SHALL have port IM_Data, input, 32 bits: fetched word.
REQ-010 SHALL have ports IF_instruct and IF_PCplus4, outputs, 32 bits each: instruction and its PC+4, sent to the IF/ID register.
REQ-011 SHALL have port IF_Valid, output, 1 bit: IF_instruct and IF_PCplus4 are meaningful.
REQ-012 SHALL have port IF_Flush, output, 1 bit: squash the IF/ID contents.

Function
REQ-013 SHALL implement a two-state FSM: FETCH and HOLD.
REQ-014 SHALL, in FETCH, drive IM_Req=1 and IM_Addr=PC.
- IM_Ready=0: IF_Valid=0.
- IM_Ready=1: IF_instruct=IM_Data and IF_Valid=1, both combinational.
REQ-015 SHALL, in FETCH with IM_Ready=1 and IF_Stall=1, capture IM_Data into the instruction buffer and enter HOLD.
REQ-016 SHALL, in HOLD, drive IM_Req=0, IF_instruct=buffer and IF_Valid=1, and remain in HOLD while IF_Stall=1.
REQ-017 SHALL treat an instruction as consumed when IF_Valid=1 and IF_Stall=0; on consumption PC loads next-PC and the FSM enters FETCH.
REQ-018 SHALL sustain one instruction per cycle when IM_Ready=1 and IF_Stall=0 (zero-wait memory).
REQ-019 SHALL compute next-PC as follows:
- Sequential: {PC[31], PC[30:0]+4}; bit 31 never receives a carry; 0x7FFFFFFC wraps to 0x00000000 with PC[31] kept.
REQ-020 SHALL, for branch and jump targets, use {PC[31], target[30:2], 2'b00}.
REQ-021 SHALL, for jump-register, use {JrTarget[31] & PC[31], JrTarget[30:2], 2'b00}, so user mode cannot enter kernel space.
REQ-022 SHALL use 0x80000004 for ILLOP and 0x80000008 for XADR.
REQ-023 SHALL treat PCsrc values 1-5 as a redirect, effective in any state regardless of IF_Stall or IM_Ready:
- PC loads the target at the next edge.
- Any buffered or arriving word is discarded.
- FSM enters FETCH.
- IF_Flush=1 in the same cycle (combinational).
REQ-024 SHALL abandon an outstanding fetch on redirect; IM_Addr changes the next cycle and the memory ignores the old address.
REQ-025 SHALL set IF_PCplus4 to the sequential value of the PC of the presented instruction, including in HOLD.
REQ-026 SHALL keep IM_Addr[1:0]=2'b00 at all times.

Reset
REQ-027 SHALL, while Reset=1 (asynchronously), force:
- PC=0x80000000, state=FETCH, buffer=0.
- IM_Req=0, IF_Valid=0, IF_Flush=0, IF_instruct=0, IF_PCplus4=0x80000004.
REQ-028 SHALL, when Reset asserts mid-fetch or in HOLD, discard all state; the first request after deassertion is address 0x80000000.

Verification
REQ-029 SHALL be verified for reset then zero-wait memory, IF_Stall=0, PCsrc=0 -> IM_Addr 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, IF_Valid=1 each cycle.
REQ-030 SHALL be verified for IM_Ready low for 3 cycles at PC 0x00400000 -> IM_Addr held, IF_Valid=0 for 3 cycles, then valid with IF_PCplus4=0x00400004.
REQ-031 SHALL be verified for IF_Stall=1 for 2 cycles when word 0x8C880004 arrives -> HOLD, IM_Req=0, IF_instruct=0x8C880004 stable, PC advances only after the stall drops.
REQ-032 SHALL be verified for PCsrc=1 with BranchTarget 0x00400020 during HOLD -> IF_Flush=1 that cycle, buffer dropped, next IM_Addr 0x00400020.
REQ-033 SHALL be verified for PCsrc=3 with JrTarget 0x80001000 from PC 0x00400000 -> next PC 0x00001000; from PC 0x80000010 -> next PC 0x80001000.
REQ-034 SHALL be verified for PC 0x7FFFFFFC sequential -> next PC 0x00000000; PC 0xFFFFFFFC sequential -> next PC 0x80000000.
